// File: rtl/fractal_sync_pkg.sv
// -----------------------------------------------------------------------------
// fractal_sync_pkg
//   Shared types and constants for the fractal synchronization network.
//   - SD_WIDTH            : source/destination field width
//   - REQ_LEVEL_W/REQ_ID_W: storage widths of the request struct; blocks with
//                           narrower level/id fields zero-extend into them
//   - fractal_sync_req_t  : buffered synchronization request {level, id, sd}
//   - req_check_e         : kind of RF check a request head needs
//   - req_check_type()    : classify a head by its level
// -----------------------------------------------------------------------------
package fractal_sync_pkg;

  localparam int unsigned SD_WIDTH    = 2;
  localparam int unsigned REQ_LEVEL_W = 8;
  localparam int unsigned REQ_ID_W    = 8;

  typedef struct packed {
    logic [REQ_LEVEL_W-1:0] level;
    logic [REQ_ID_W-1:0]    id;
    logic [SD_WIDTH-1:0]    sd;
  } fractal_sync_req_t;

  typedef enum logic [1:0] {
    CHK_NONE   = 2'd0,
    CHK_LOCAL  = 2'd1,
    CHK_REMOTE = 2'd2
  } req_check_e;

  // Level 1 resolves inside this node, anything above must go upward.
  // Level 0 is malformed and never reaches the RF.
  function automatic req_check_e req_check_type(input logic [REQ_LEVEL_W-1:0] level);
    if (level == '0) begin
      return CHK_NONE;
    end else if (level == REQ_LEVEL_W'(1)) begin
      return CHK_LOCAL;
    end else begin
      return CHK_REMOTE;
    end
  endfunction

endpackage

// File: rtl/fractal_sync_1d_req_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// fractal_sync_req_fifo
//   Per-port request FIFO. Push and pop may happen in the same cycle; a push
//   into a full FIFO is accepted only together with a pop (used to re-queue
//   the head at the tail). No fall-through: a pushed entry is visible at the
//   head the cycle after the push at the earliest.
//   Ports:
//     clk_i, rst_ni : clock, asynchronous active-low reset
//     push_i/data_i : enqueue request
//     pop_i         : dequeue head (ignored when empty)
//     head_o        : current head entry (meaningful when !empty_o)
//     full_o/empty_o: occupancy flags
// -----------------------------------------------------------------------------
module fractal_sync_req_fifo
  import fractal_sync_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  fractal_sync_req_t data_i,
  input  logic              pop_i,
  output fractal_sync_req_t head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fractal_sync_req_t mem_d [DEPTH];
  fractal_sync_req_t mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              push_en, pop_en;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A simultaneous pop frees the slot a full-FIFO push needs.
  assign push_en = push_i && (!full_o || pop_i);
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/fractal_sync_1d_req_ctrl.sv
// -----------------------------------------------------------------------------
// fractal_sync_1d_req_ctrl
//   Request-control stage in front of the 1D synchronization register file.
//   Each port buffers requests in a FIFO, presents the head to the RF with a
//   local or remote check strobe, and acts on the RF verdict in the same
//   cycle: pop, re-queue (bypass), forward upward, or emit a wake-up.
//   Ports are fully independent.
//   Ports (all per port [N_PORTS]):
//     req_*         : incoming request channel (valid/ready, level/id/sd)
//     level_o/id_o/sd_local_o, check_local_o/check_remote_o : head to RF
//     present_*/bypass_*/ignore_*/id_err_i/sig_err_i/sd_local_i : RF verdict
//     fwd_*         : upward channel, one-entry registered stage
//     wake_*        : downward wake channel, one-entry registered stage
//     err_o         : registered one-cycle error pulse
//   Optional: define FRACTAL_SYNC_REQ_STATS_EN to add saturating counters
//     bypass_cnt_o (16 bit) and err_cnt_o (8 bit) per port.
// -----------------------------------------------------------------------------
module fractal_sync_1d_req_ctrl
  import fractal_sync_pkg::*;
#(
  parameter int unsigned N_PORTS     = 2,
  parameter int unsigned LEVEL_WIDTH = 1,
  parameter int unsigned ID_WIDTH    = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // request channel
  input  logic                   req_valid_i      [N_PORTS],
  output logic                   req_ready_o      [N_PORTS],
  input  logic [LEVEL_WIDTH-1:0] req_level_i      [N_PORTS],
  input  logic [ID_WIDTH-1:0]    req_id_i         [N_PORTS],
  input  logic [SD_WIDTH-1:0]    req_sd_i         [N_PORTS],
  // head to RF
  output logic [LEVEL_WIDTH-1:0] level_o          [N_PORTS],
  output logic [ID_WIDTH-1:0]    id_o             [N_PORTS],
  output logic [SD_WIDTH-1:0]    sd_local_o       [N_PORTS],
  output logic                   check_local_o    [N_PORTS],
  output logic                   check_remote_o   [N_PORTS],
  // RF verdict
  input  logic                   present_local_i  [N_PORTS],
  input  logic                   present_remote_i [N_PORTS],
  input  logic                   bypass_local_i   [N_PORTS],
  input  logic                   bypass_remote_i  [N_PORTS],
  input  logic                   ignore_local_i   [N_PORTS],
  input  logic                   ignore_remote_i  [N_PORTS],
  input  logic                   id_err_i         [N_PORTS],
  input  logic                   sig_err_i        [N_PORTS],
  input  logic [SD_WIDTH-1:0]    sd_local_i       [N_PORTS],
  // upward channel
  output logic                   fwd_valid_o      [N_PORTS],
  input  logic                   fwd_ready_i      [N_PORTS],
  output logic [LEVEL_WIDTH-1:0] fwd_level_o      [N_PORTS],
  output logic [ID_WIDTH-1:0]    fwd_id_o         [N_PORTS],
  // wake channel
  output logic                   wake_valid_o     [N_PORTS],
  input  logic                   wake_ready_i     [N_PORTS],
  output logic [ID_WIDTH-1:0]    wake_id_o        [N_PORTS],
  output logic [SD_WIDTH-1:0]    wake_sd_o        [N_PORTS],
  output logic                   err_o            [N_PORTS]
`ifdef FRACTAL_SYNC_REQ_STATS_EN
  ,
  output logic [15:0]            bypass_cnt_o     [N_PORTS],
  output logic [7:0]             err_cnt_o        [N_PORTS]
`endif
);

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port

    fractal_sync_req_t     push_data, head;
    logic                  push, pop, full, empty, head_valid, ready;
    req_check_e            chk_type;
    logic                  wake_free, fwd_free;
    logic                  chk_local, chk_remote, chk_any, lvl_zero;
    logic                  vd_err, vd_ignore, vd_bypass, wake_load, fwd_load;
    logic                  unused_head_id;

    logic                   wake_valid_d, wake_valid_q;
    logic [ID_WIDTH-1:0]    wake_id_d, wake_id_q;
    logic [SD_WIDTH-1:0]    wake_sd_d, wake_sd_q;
    logic                   fwd_valid_d, fwd_valid_q;
    logic [LEVEL_WIDTH-1:0] fwd_level_d, fwd_level_q;
    logic [ID_WIDTH-1:0]    fwd_id_d, fwd_id_q;
    logic                   err_d, err_q;

    fractal_sync_req_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (push_data),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
    );

    // Only the low ID_WIDTH bits of the stored id carry information.
    assign unused_head_id = ^head.id;

    // Check gating and same-cycle verdict decode. A bypass re-push always
    // coincides with its own pop, so it can never be blocked by a full FIFO
    // and needs no gating term of its own.
    always_comb begin
      head_valid = !empty;
      chk_type   = req_check_type(head.level);
      wake_free  = !wake_valid_q || wake_ready_i[p];
      fwd_free   = !fwd_valid_q || fwd_ready_i[p];
      chk_local  = head_valid && (chk_type == CHK_LOCAL) && wake_free;
      chk_remote = head_valid && (chk_type == CHK_REMOTE) && fwd_free;
      chk_any    = chk_local || chk_remote;
      lvl_zero   = head_valid && (chk_type == CHK_NONE);

      vd_err    = chk_any && (id_err_i[p] || sig_err_i[p]);
      vd_ignore = !vd_err &&
                  ((chk_local && ignore_local_i[p]) || (chk_remote && ignore_remote_i[p]));
      vd_bypass = !vd_err && !vd_ignore &&
                  ((chk_local && bypass_local_i[p]) || (chk_remote && bypass_remote_i[p]));
      wake_load = chk_local && !vd_err && !vd_ignore && !vd_bypass && present_local_i[p];
      fwd_load  = chk_remote && !vd_err && !vd_ignore && !vd_bypass && !present_remote_i[p];

      pop   = chk_any || lvl_zero;
      // The tail slot belongs to the re-queued head while a bypass is in flight.
      ready = !full && !vd_bypass;
      push  = vd_bypass || (req_valid_i[p] && ready);
      if (vd_bypass) begin
        push_data = head;
      end else begin
        push_data.level = REQ_LEVEL_W'(req_level_i[p]);
        push_data.id    = REQ_ID_W'(req_id_i[p]);
        push_data.sd    = req_sd_i[p];
      end
    end

    // Output stages: a load only happens when the stage is empty or draining,
    // so held data never changes while valid && !ready.
    always_comb begin
      wake_valid_d = wake_valid_q;
      wake_id_d    = wake_id_q;
      wake_sd_d    = wake_sd_q;
      if (wake_valid_q && wake_ready_i[p]) begin
        wake_valid_d = 1'b0;
      end
      if (wake_load) begin
        wake_valid_d = 1'b1;
        wake_id_d    = head.id[ID_WIDTH-1:0];
        wake_sd_d    = sd_local_i[p];
      end

      fwd_valid_d = fwd_valid_q;
      fwd_level_d = fwd_level_q;
      fwd_id_d    = fwd_id_q;
      if (fwd_valid_q && fwd_ready_i[p]) begin
        fwd_valid_d = 1'b0;
      end
      if (fwd_load) begin
        fwd_valid_d = 1'b1;
        fwd_level_d = head.level[LEVEL_WIDTH-1:0] - 1'b1;
        fwd_id_d    = head.id[ID_WIDTH-1:0];
      end

      err_d = vd_err || lvl_zero;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wake_valid_q <= 1'b0;
        wake_id_q    <= '0;
        wake_sd_q    <= '0;
        fwd_valid_q  <= 1'b0;
        fwd_level_q  <= '0;
        fwd_id_q     <= '0;
        err_q        <= 1'b0;
      end else begin
        wake_valid_q <= wake_valid_d;
        wake_id_q    <= wake_id_d;
        wake_sd_q    <= wake_sd_d;
        fwd_valid_q  <= fwd_valid_d;
        fwd_level_q  <= fwd_level_d;
        fwd_id_q     <= fwd_id_d;
        err_q        <= err_d;
      end
    end

    assign req_ready_o[p]    = ready;
    // Head fields are forced to zero when the FIFO is empty.
    assign level_o[p]        = head_valid ? head.level[LEVEL_WIDTH-1:0] : '0;
    assign id_o[p]           = head_valid ? head.id[ID_WIDTH-1:0] : '0;
    assign sd_local_o[p]     = head_valid ? head.sd : '0;
    assign check_local_o[p]  = chk_local;
    assign check_remote_o[p] = chk_remote;
    assign fwd_valid_o[p]    = fwd_valid_q;
    assign fwd_level_o[p]    = fwd_level_q;
    assign fwd_id_o[p]       = fwd_id_q;
    assign wake_valid_o[p]   = wake_valid_q;
    assign wake_id_o[p]      = wake_id_q;
    assign wake_sd_o[p]      = wake_sd_q;
    assign err_o[p]          = err_q;

`ifdef FRACTAL_SYNC_REQ_STATS_EN
    logic [15:0] bypass_cnt_d, bypass_cnt_q;
    logic [7:0]  err_cnt_d, err_cnt_q;

    always_comb begin
      bypass_cnt_d = bypass_cnt_q;
      err_cnt_d    = err_cnt_q;
      if (vd_bypass && (bypass_cnt_q != '1)) begin
        bypass_cnt_d = bypass_cnt_q + 1'b1;
      end
      if (err_d && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        bypass_cnt_q <= '0;
        err_cnt_q    <= '0;
      end else begin
        bypass_cnt_q <= bypass_cnt_d;
        err_cnt_q    <= err_cnt_d;
      end
    end

    assign bypass_cnt_o[p] = bypass_cnt_q;
    assign err_cnt_o[p]    = err_cnt_q;
`endif

  end

endmodule
